sum_bcd_display: RTL and testbench

- Downstream consumer of the 9-bit adder sum `S_0`.
- Accepts a sum through a valid/ready handshake and converts it to 3-digit BCD with a sequential double-dabble (shift-add-3) engine.
- Drives the board's 4-digit multiplexed, active-low 7-segment display from the last completed result.
- Sits between the adder output and the board display pins, in the same clock domain as the adder.

---
 rtl/sum_bcd_display.sv | 158 +++++++++++++++
 tb/tb_sum_bcd_display.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sum_bcd_display.sv
// rtl/sum_bcd_display.sv - sequential double-dabble converter feeding a 4-digit multiplexed 7-segment display
// Accepts one sum per handshake; the display always shows the last completed result.
module sum_bcd_display #(
   parameter int IN_W        = 9,
   parameter int REFRESH_DIV = 100000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [IN_W-1:0] sum_in,
   input  logic            sum_valid,
   output logic            sum_ready,
   output logic [11:0]     bcd,
   output logic            bcd_valid,
   output logic [3:0]      an,
   output logic [6:0]      seg,
   output logic            dp
);

   localparam int CW = $clog2(IN_W + 1);
   localparam int RW = $clog2(REFRESH_DIV);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t          state_q, state_d;
   logic [IN_W-1:0] bin_q, bin_d;
   logic [11:0]     scratch_q, scratch_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [11:0]     bcd_q, bcd_d;
   logic            bcd_valid_q, bcd_valid_d;
   logic            sum_ready_q, sum_ready_d;
   logic [RW-1:0]   refresh_q, refresh_d;
   logic [1:0]      slot_q, slot_d;
   logic [3:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic [11:0]     adj;
   logic            blank_h, blank_t;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'b1000000;
         4'd1:    seg_code = 7'b1111001;
         4'd2:    seg_code = 7'b0100100;
         4'd3:    seg_code = 7'b0110000;
         4'd4:    seg_code = 7'b0011001;
         4'd5:    seg_code = 7'b0010010;
         4'd6:    seg_code = 7'b0000010;
         4'd7:    seg_code = 7'b1111000;
         4'd8:    seg_code = 7'b0000000;
         4'd9:    seg_code = 7'b0010000;
         default: seg_code = 7'b1111111;
      endcase
   endfunction

   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      scratch_d   = scratch_q;
      cnt_d       = cnt_q;
      bcd_d       = bcd_q;
      bcd_valid_d = 1'b0;
      adj         = scratch_q;
      for (int i = 0; i < 3; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
      case (state_q)
         IDLE: begin
            if (sum_valid && sum_ready_q) begin
               bin_d     = sum_in;
               scratch_d = '0;
               cnt_d     = CW'(IN_W);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = {adj[10:0], bin_q[IN_W-1]};
            bin_d     = bin_q << 1;
            cnt_d     = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = DONE;
         end
         DONE: begin
            bcd_d       = scratch_q;
            bcd_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
      sum_ready_d = (state_d == IDLE);
   end

   // Display slot scan; the result register is read live so a new value appears without restarting the scan.
   always_comb begin
      refresh_d = refresh_q + 1'b1;
      slot_d    = slot_q;
      if (refresh_q == RW'(REFRESH_DIV - 1)) begin
         refresh_d = '0;
         slot_d    = slot_q + 2'd1;
      end
      blank_h = (bcd_q[11:8] == 4'd0);
      blank_t = blank_h && (bcd_q[7:4] == 4'd0);
      an_d    = 4'b1111;
      seg_d   = 7'b1111111;
      case (slot_q)
         2'd0: begin
            an_d  = 4'b1110;
            seg_d = seg_code(bcd_q[3:0]);
         end
         2'd1: begin
            if (!blank_t) begin
               an_d  = 4'b1101;
               seg_d = seg_code(bcd_q[7:4]);
            end
         end
         2'd2: begin
            if (!blank_h) begin
               an_d  = 4'b1011;
               seg_d = seg_code(bcd_q[11:8]);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         scratch_q   <= '0;
         cnt_q       <= '0;
         bcd_q       <= '0;
         bcd_valid_q <= 1'b0;
         sum_ready_q <= 1'b0;
         refresh_q   <= '0;
         slot_q      <= '0;
         an_q        <= 4'b1111;
         seg_q       <= 7'b1111111;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         scratch_q   <= scratch_d;
         cnt_q       <= cnt_d;
         bcd_q       <= bcd_d;
         bcd_valid_q <= bcd_valid_d;
         sum_ready_q <= sum_ready_d;
         refresh_q   <= refresh_d;
         slot_q      <= slot_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   assign sum_ready = sum_ready_q;
   assign bcd       = bcd_q;
   assign bcd_valid = bcd_valid_q;
   assign an        = an_q;
   assign seg       = seg_q;
   assign dp        = 1'b1;

endmodule

// File: tb/tb_sum_bcd_display.sv
// tb/tb_sum_bcd_display.sv - directed scoreboard bench for sum_bcd_display
// Expected BCD values are queued at drive time and popped when bcd_valid appears.
module tb_sum_bcd_display;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [8:0]  sum_in = '0;
   logic        sum_valid = 1'b0;
   logic        sum_ready;
   logic [11:0] bcd;
   logic        bcd_valid;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [11:0] exp_q[$];

   sum_bcd_display #(.IN_W(9), .REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .sum_in(sum_in), .sum_valid(sum_valid), .sum_ready(sum_ready),
      .bcd(bcd), .bcd_valid(bcd_valid), .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic pop_chk(input string tag);
      logic [11:0] e;
      chk({tag, "_queue_nonempty"}, 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk(tag, 32'(bcd), 32'(e));
      end
   endtask

   task automatic wait_ready();
      int i;
      for (i = 0; i < 30 && sum_ready !== 1'b1; i++) @(negedge clk);
      chk("wait_ready", 32'(sum_ready), 1);
   endtask

   // Single handshake, then check ready/valid timing and the result edge by edge.
   task automatic convert(input int v);
      wait_ready();
      sum_in = 9'(v);
      sum_valid = 1'b1;
      exp_q.push_back(to_bcd(v));
      @(posedge clk);
      @(negedge clk);
      sum_valid = 1'b0;
      chk("ready_after_accept", 32'(sum_ready), 0);
      for (int lat = 1; lat <= 11; lat++) begin
         @(posedge clk);
         @(negedge clk);
         if (lat < 10) begin
            chk("ready_low_busy", 32'(sum_ready), 0);
            chk("valid_early", 32'(bcd_valid), 0);
         end else if (lat == 10) begin
            chk("valid_at_10", 32'(bcd_valid), 1);
            chk("ready_back", 32'(sum_ready), 1);
            pop_chk("bcd_result");
         end else begin
            chk("valid_single_pulse", 32'(bcd_valid), 0);
         end
      end
   endtask

   task automatic disp(input string tag, input logic [15:0] ea, input logic [27:0] es);
      int i;
      logic [3:0] prev;
      prev = an;
      for (i = 0; i < 64; i++) begin
         @(negedge clk);
         if (an == 4'b1110 && prev != 4'b1110) break;
         prev = an;
      end
      chk({tag, "_sync"}, 32'(an), 32'(4'b1110));
      for (int c = 0; c < 32; c++) begin
         chk({tag, "_an"}, 32'(an), 32'(ea[4*((c % 16) / 4) +: 4]));
         chk({tag, "_seg"}, 32'(seg), 32'(es[7*((c % 16) / 4) +: 7]));
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(sum_ready), 0);
      chk("rst_bcd", 32'(bcd), 0);
      chk("rst_valid", 32'(bcd_valid), 0);
      chk("rst_an", 32'(an), 32'(4'b1111));
      chk("rst_seg", 32'(seg), 32'(7'b1111111));
      chk("rst_dp", 32'(dp), 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("ready_after_release", 32'(sum_ready), 1);

      convert(510);

      // Back-to-back with sum_valid held high; mid-conversion input change must be ignored.
      wait_ready();
      sum_in = 9'd255;
      sum_valid = 1'b1;
      exp_q.push_back(to_bcd(255));
      @(posedge clk);
      for (int lat = 1; lat <= 22; lat++) begin
         @(posedge clk);
         @(negedge clk);
         if (lat == 3) begin
            sum_in = 9'd7;
            exp_q.push_back(to_bcd(7));
         end
         if (lat == 11) begin
            chk("b2b_second_accept", 32'(sum_ready), 0);
            sum_valid = 1'b0;
         end
         chk("b2b_valid", 32'(bcd_valid), 32'(lat == 10 || lat == 21));
         if (lat == 10) pop_chk("b2b_first");
         if (lat == 21) pop_chk("b2b_second");
      end

      convert(7);
      disp("disp7", 16'b1111_1111_1111_1110,
           {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000});
      convert(0);
      disp("disp0", 16'b1111_1111_1111_1110,
           {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
      convert(100);
      disp("disp100", 16'b1111_1011_1101_1110,
           {7'b1111111, 7'b1111001, 7'b1000000, 7'b1000000});
      convert(9);
      disp("disp9", 16'b1111_1111_1111_1110,
           {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010000});
      convert(511);
      disp("disp511", 16'b1111_1011_1101_1110,
           {7'b1111111, 7'b0010010, 7'b1111001, 7'b1111001});

      // Reset in the middle of a conversion abandons it.
      wait_ready();
      sum_in = 9'd300;
      sum_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      sum_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 15; c++) begin
         chk("midrst_no_valid", 32'(bcd_valid), 0);
         chk("midrst_bcd", 32'(bcd), 0);
         @(negedge clk);
      end
      convert(300);

      chk("queue_drained", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
